// File: rtl/axi_rd_burst_ctlr.sv
// AXI4 read master: splits one multi-beat request into INCR bursts and streams beats out.
// Optional macro AXI_RD_4K_SPLIT_EN keeps every burst inside a 4 KB page.
module axi_rd_burst_ctlr #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 128,
  parameter int ID_W      = 4,
  parameter int ARID_VAL  = 0,
  parameter int MAX_BEATS = 16,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [CNT_W-1:0]  req_beats,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DATA_W-1:0] dout_data,
  output logic              dout_last,
  output logic              done_valid,
  output logic              done_err,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [ID_W-1:0]   arid,
  output logic              arvalid,
  input  logic              arready,
  output logic              arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic [3:0]        arqos,
  input  logic [DATA_W-1:0] rdata,
  input  logic [ID_W-1:0]   rid,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int SIZE  = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, AR, DATA, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remain;
  logic [CNT_W-1:0]  bcnt;
  logic [CNT_W-1:0]  burst;
  logic              err;

  logic [ADDR_W-1:0] nxt_addr;
  logic [CNT_W-1:0]  nxt_rem;
  logic [CNT_W-1:0]  burst_nxt;
  logic [7:0]        arlen_nxt;
  logic              beat;
  logic              beat_err;
  logic              proto_err;
  logic              early_last;
  logic              burst_end;
  logic              new_err;

`ifdef AXI_RD_4K_SPLIT_EN
  logic [12:0]       room;
`endif

  assign arsize  = 3'(SIZE);
  assign arburst = 2'b01;
  assign arid    = ID_W'(ARID_VAL);
  assign arlock  = 1'b0;
  assign arcache = 4'h0;
  assign arprot  = 3'h2;
  assign arqos   = 4'h0;

  // R channel is a straight pass-through while a burst is being received
  assign rready     = (state == DATA) & dout_ready;
  assign dout_valid = (state == DATA) & rvalid;
  assign dout_data  = (state == DATA) ? rdata : '0;
  assign beat       = (state == DATA) & rvalid & dout_ready;

  assign burst_end  = rlast | (bcnt == CNT_W'(1));
  assign early_last = rlast & (bcnt != CNT_W'(1));
  assign proto_err  = rlast ^ (bcnt == CNT_W'(1));
  assign beat_err   = (rresp != 2'b00) | (rid != ID_W'(ARID_VAL));
  assign new_err    = err | beat_err | proto_err;
  assign dout_last  = (state == DATA) & ((remain == CNT_W'(1)) | early_last);

  // Address/count for the next AR: fresh request in IDLE, continuation after a burst otherwise
  always_comb begin
    nxt_addr = cur_addr + (ADDR_W'(burst) << SIZE);
    nxt_rem  = remain - CNT_W'(1);
    if (state == IDLE) begin
      nxt_addr = req_addr & ~ADDR_W'(BYTES - 1);
      nxt_rem  = (req_beats == '0) ? CNT_W'(1) : req_beats;
    end
    burst_nxt = nxt_rem;
`ifdef AXI_RD_4K_SPLIT_EN
    room = (13'h1000 - {1'b0, nxt_addr[11:0]}) >> SIZE;
    if ({19'd0, room} < 32'(nxt_rem)) burst_nxt = CNT_W'(room);
`endif
    arlen_nxt = 8'(9'(burst_nxt) - 9'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      arvalid    <= 1'b0;
      araddr     <= '0;
      arlen      <= '0;
      done_valid <= 1'b0;
      done_err   <= 1'b0;
      cur_addr   <= '0;
      remain     <= '0;
      bcnt       <= '0;
      burst      <= '0;
      err        <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            cur_addr  <= nxt_addr;
            remain    <= nxt_rem;
            burst     <= burst_nxt;
            araddr    <= nxt_addr;
            arlen     <= arlen_nxt;
            arvalid   <= 1'b1;
            err       <= 1'b0;
            state     <= AR;
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            bcnt    <= burst;
            state   <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            bcnt   <= bcnt - CNT_W'(1);
            remain <= nxt_rem;
            err    <= new_err;
            if (burst_end) begin
              // An early rlast abandons the rest of the request
              if (early_last || nxt_rem == '0) begin
                done_valid <= 1'b1;
                done_err   <= new_err;
                state      <= DONE;
              end else begin
                cur_addr <= nxt_addr;
                burst    <= burst_nxt;
                araddr   <= nxt_addr;
                arlen    <= arlen_nxt;
                arvalid  <= 1'b1;
                state    <= AR;
              end
            end
          end
        end
        DONE: begin
          done_err  <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_ctlr.sv
// Scoreboard bench for axi_rd_burst_ctlr: directed requests, a scripted AXI slave and a
// monitor that pops expected AR / beat / completion records as the DUT presents them.
module tb_axi_rd_burst_ctlr;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 128;
  localparam int ID_W      = 4;
  localparam int MAX_BEATS = 16;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);

  logic              clk, rst_n;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [CNT_W-1:0]  req_beats;
  logic              dout_valid, dout_ready, dout_last;
  logic [DATA_W-1:0] dout_data;
  logic              done_valid, done_err;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize, arprot;
  logic [1:0]        arburst, rresp;
  logic [ID_W-1:0]   arid, rid;
  logic              arvalid, arready, arlock, rlast, rvalid, rready;
  logic [3:0]        arcache, arqos;
  logic [DATA_W-1:0] rdata;

  axi_rd_burst_ctlr #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .ARID_VAL(0), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_beats(req_beats),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last),
    .done_valid(done_valid), .done_err(done_err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
    .arvalid(arvalid), .arready(arready), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arqos(arqos),
    .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [127:0] data; logic last; } beat_t;
  typedef struct { logic err; int cyc; } done_t;

  ar_t   ar_q[$];
  beat_t beat_q[$];
  done_t done_q[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit bp = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp) dout_ready = ~dout_ready;
      else    dout_ready = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: DUT output with no expected entry", nm);
  endtask

  function automatic logic [127:0] pat(input logic [63:0] a, input int i);
    return {32'hC0DE0000 ^ 32'(i), 32'h5A5A5A5A, a};
  endfunction

  // Monitor: compares every DUT presentation against the head of its queue
  initial begin
    ar_t   ea;
    beat_t eb;
    done_t ed;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (arvalid && arready) begin
          if (ar_q.size() == 0) unexpected("ar");
          else begin
            ea = ar_q.pop_front();
            chk("araddr", araddr, ea.addr);
            chk("arlen", arlen, ea.len);
            chk("arsize_arburst", {arsize, arburst}, {3'd4, 2'b01});
          end
        end
        if (dout_valid && dout_ready) begin
          if (beat_q.size() == 0) unexpected("beat");
          else begin
            eb = beat_q.pop_front();
            chk("dout_data", dout_data, eb.data);
            chk("dout_last", dout_last, eb.last);
          end
        end
        if (done_valid) begin
          if (done_q.size() == 0) unexpected("done");
          else begin
            ed = done_q.pop_front();
            chk("done_err", done_err, ed.err);
            if (ed.cyc >= 0) chk("done_latency", cyc, ed.cyc);
          end
        end
      end
    end
  end

  function automatic logic cond(input int which);
    case (which)
      0:       return req_ready;
      1:       return arvalid && arready;
      default: return rready;
    endcase
  endfunction

  // Bounded wait at the falling edge; the handshake then happens on the next rising edge
  task automatic wait_for(input int which, input string nm);
    bit seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (cond(which)) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout_%s: got no handshake expected one within 40 cycles", nm);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_ctl"}, {req_ready, arvalid, rready, dout_valid, dout_last, done_valid, done_err}, 7'd0);
    chk({nm, "_araddr_arlen"}, {araddr, arlen}, 72'd0);
    chk({nm, "_dout_data"}, dout_data, 128'd0);
    chk({nm, "_const"}, {arlock, arcache, arqos, arprot, arsize, arburst, arid},
        {1'b0, 4'h0, 4'h0, 3'h2, 3'd4, 2'b01, 4'h0});
  endtask

  // beats: requested count; err_beat: beat with SLVERR; early: beat carrying early rlast;
  // b1: size of the first burst when the request is expected to split; lat: expected done latency
  task automatic run_req(input logic [63:0] addr, input int beats, input int err_beat,
                         input int early, input int b1, input int lat);
    int eff, n_out, t_hs, bsz, sent;
    logic [63:0] a;
    eff   = (beats == 0) ? 1 : beats;
    n_out = (early != 0) ? early : eff;
    a     = addr & ~64'hF;
    if (b1 == 0 || b1 >= eff) ar_q.push_back('{a, 8'(eff - 1)});
    else begin
      ar_q.push_back('{a, 8'(b1 - 1)});
      ar_q.push_back('{a + 64'(b1 * 16), 8'(eff - b1 - 1)});
    end
    for (int i = 1; i <= n_out; i++) beat_q.push_back('{pat(addr, i), i == n_out});

    req_addr  = addr;
    req_beats = CNT_W'(beats);
    req_valid = 1'b1;
    wait_for(0, "req");
    t_hs = cyc;
    done_q.push_back('{(err_beat != 0) || (early != 0), (lat >= 0) ? t_hs + lat : -1});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    arready   = 1'b1;

    sent = 0;
    while (sent < n_out) begin
      wait_for(1, "ar");
      @(posedge clk);
      #1;
      arready = 1'b0;
      bsz = (b1 != 0 && sent == 0 && b1 < eff) ? b1 : eff - sent;
      @(posedge clk);
      #1;
      for (int j = 0; j < bsz && sent < n_out; j++) begin
        rvalid = 1'b1;
        rdata  = pat(addr, sent + 1);
        rresp  = (sent + 1 == err_beat) ? 2'b10 : 2'b00;
        rlast  = (early != 0) ? (sent + 1 == early) : (j == bsz - 1);
        wait_for(2, "r");
        @(posedge clk);
        #1;
        sent++;
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      if (sent < n_out) arready = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_beats = '0;
    arready = 1'b0;
    rvalid = 1'b0;
    rlast = 1'b0;
    rresp = 2'b00;
    rid = '0;
    rdata = '0;
    #3;
    chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("req_ready_after_reset", req_ready, 1'b1);

    run_req(64'h1000, 1, 0, 0, 0, 4);    // single beat, done 4 cycles after handshake
    run_req(64'h2007, 3, 0, 0, 0, 6);    // unaligned address is forced to 0x2000
    run_req(64'h2100, 0, 0, 0, 0, 4);    // zero beats behaves as one
    bp = 1;
    run_req(64'h0, 16, 0, 0, 0, -1);     // 16 beats with backpressure
    bp = 0;
    run_req(64'h5000, 8, 3, 0, 0, -1);   // SLVERR on beat 3
    run_req(64'h6000, 4, 0, 2, 0, -1);   // rlast on beat 2 of 4
`ifdef AXI_RD_4K_SPLIT_EN
    run_req(64'hFC0, 8, 0, 0, 4, -1);    // 0xFC0 + 8x16B crosses 4 KB: two 4-beat bursts
`endif

    // Reset in the middle of a 4-beat burst
    repeat (3) @(posedge clk);
    #1;
    ar_q.push_back('{64'h3000, 8'd3});
    beat_q.push_back('{pat(64'h3000, 1), 1'b0});
    req_addr  = 64'h3000;
    req_beats = CNT_W'(4);
    req_valid = 1'b1;
    wait_for(0, "req");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    arready   = 1'b1;
    wait_for(1, "ar");
    @(posedge clk);
    #1;
    arready = 1'b0;
    @(posedge clk);
    #1;
    rvalid = 1'b1;
    rdata  = pat(64'h3000, 1);
    wait_for(2, "r");
    @(posedge clk);
    #1;
    rdata = pat(64'h3000, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midburst_reset");
    rvalid = 1'b0;
    chk("queues_after_reset", {32'(ar_q.size()), 32'(beat_q.size()), 32'(done_q.size())}, 96'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("req_ready_after_release", req_ready, 1'b1);
    run_req(64'h4000, 2, 0, 0, 0, 5);

    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ar_q.size() == 0 && beat_q.size() == 0 && done_q.size() == 0) break;
    end
    repeat (3) @(negedge clk);
    chk("ar_q_drained", 32'(ar_q.size()), 32'd0);
    chk("beat_q_drained", 32'(beat_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
